// File: rtl/adci_pkg.sv
// adci_pkg: shared constants, state encodings and helpers for the ADC serial interface.
package adci_pkg;

  // Defaults for adci_interface parameters.
  localparam int unsigned SCK_HALF_DEF    = 2;
  localparam int unsigned CSN_IDLE_DEF    = 4;
  localparam int unsigned STARTUP_DLY_DEF = 256;
  localparam logic [15:0] CMD_DEF         = 16'h0000;

  // Frame geometry and the slice of the result that is presented.
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned RES_MSB    = 11;
  localparam int unsigned RES_LSB    = 4;
  localparam int unsigned DATA_W     = RES_MSB - RES_LSB + 1;

  // Counter widths.
  localparam int unsigned STARTUP_W = 16;
  localparam int unsigned PHASE_W   = 16;
  localparam int unsigned BIT_W     = 4;

  // State encodings.
  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_STARTUP = 3'd0;
  localparam logic [STATE_W-1:0] ST_LEAD    = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOW     = 3'd2;
  localparam logic [STATE_W-1:0] ST_HIGH    = 3'd3;
  localparam logic [STATE_W-1:0] ST_TRAIL   = 3'd4;
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd5;

  // Command bit driven during bit slot idx (MSB first).
  function automatic logic cmd_bit(input logic [15:0] cmd, input logic [BIT_W-1:0] idx);
    return cmd[BIT_W'(FRAME_BITS - 1) - idx];
  endfunction

endpackage

// File: rtl/adci_interface.sv
// adci_interface: SPI master for a 12-bit serial ADC (16-SCK frames, SCK idles high).
// Runs back-to-back frames after a start-up delay, shifts CMD out on SDO and
// presents result[11:4] on DATA_READ with a one-cycle RX_DONE strobe.
// Ports:
//   sys_clk    system clock, rising edge
//   en         asynchronous active-low reset
//   SDI        ADC DOUT
//   SDO        ADC DIN (command bits)
//   SCK        serial clock, idles high
//   CSN        ADC chip select, active low
//   DATA_READ  last conversion result[11:4]
//   RX_DONE    one-cycle pulse when DATA_READ updates
module adci_interface
  import adci_pkg::*;
#(
  parameter int unsigned SCK_HALF    = SCK_HALF_DEF,
  parameter int unsigned CSN_IDLE    = CSN_IDLE_DEF,
  parameter int unsigned STARTUP_DLY = STARTUP_DLY_DEF,
  parameter logic [15:0] CMD         = CMD_DEF
) (
  input  logic       sys_clk,
  input  logic       en,
  input  logic       SDI,
  output logic       SDO,
  output logic       SCK,
  output logic       CSN,
  output logic [7:0] DATA_READ,
  output logic       RX_DONE
);

  logic [STATE_W-1:0]    state, state_nxt;
  logic [PHASE_W-1:0]    phase, phase_nxt;
  logic [BIT_W-1:0]      bit_idx, bit_nxt;
  logic [FRAME_BITS-1:0] shift, shift_nxt;
  logic [STARTUP_W-1:0]  startup_cnt, startup_nxt;
  logic                  sck_nxt, csn_nxt, sdo_nxt, rx_done_nxt;
  logic [7:0]            data_nxt;

  logic half_done_c, idle_done_c, startup_done_c, last_bit_c;

  // Terminal-count detects; written as >= so a parameter of 0 behaves like 1.
  assign half_done_c    = (32'(phase) + 32'd1) >= SCK_HALF;
  assign idle_done_c    = (32'(phase) + 32'd1) >= CSN_IDLE;
  assign startup_done_c = (32'(startup_cnt) + 32'd1) >= STARTUP_DLY;
  assign last_bit_c     = bit_idx == BIT_W'(FRAME_BITS - 1);

  // State and output registers; outputs are loaded together with the state they belong to.
  always_ff @(posedge sys_clk or negedge en) begin
    if (!en) begin
      state       <= ST_STARTUP;
      phase       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      startup_cnt <= '0;
      SCK         <= 1'b1;
      CSN         <= 1'b1;
      SDO         <= 1'b0;
      DATA_READ   <= '0;
      RX_DONE     <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      bit_idx     <= bit_nxt;
      shift       <= shift_nxt;
      startup_cnt <= startup_nxt;
      SCK         <= sck_nxt;
      CSN         <= csn_nxt;
      SDO         <= sdo_nxt;
      DATA_READ   <= data_nxt;
      RX_DONE     <= rx_done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase + PHASE_W'(1);
    bit_nxt     = bit_idx;
    shift_nxt   = shift;
    startup_nxt = startup_cnt;
    sck_nxt     = SCK;
    csn_nxt     = CSN;
    sdo_nxt     = SDO;
    data_nxt    = DATA_READ;
    rx_done_nxt = 1'b0;

    case (state)
      ST_STARTUP: begin
        phase_nxt   = '0;
        startup_nxt = startup_cnt + STARTUP_W'(1);
        if (startup_done_c) begin
          state_nxt = ST_LEAD;
          csn_nxt   = 1'b0;
          sck_nxt   = 1'b1;
          bit_nxt   = '0;
          sdo_nxt   = cmd_bit(CMD, '0);
        end
      end
      ST_LEAD: begin
        if (half_done_c) begin
          state_nxt = ST_LOW;
          phase_nxt = '0;
          sck_nxt   = 1'b0;
          sdo_nxt   = cmd_bit(CMD, bit_idx);
        end
      end
      ST_LOW: begin
        // SDI is captured on the same edge that raises SCK.
        if (half_done_c) begin
          state_nxt = ST_HIGH;
          phase_nxt = '0;
          sck_nxt   = 1'b1;
          shift_nxt = (shift << 1) | FRAME_BITS'(SDI);
        end
      end
      ST_HIGH: begin
        if (half_done_c) begin
          phase_nxt = '0;
          if (last_bit_c) begin
            state_nxt = ST_TRAIL;
          end else begin
            state_nxt = ST_LOW;
            bit_nxt   = bit_idx + BIT_W'(1);
            sck_nxt   = 1'b0;
            sdo_nxt   = cmd_bit(CMD, bit_idx + BIT_W'(1));
          end
        end
      end
      ST_TRAIL: begin
        // Publishing here keeps DATA_READ whole: the last sample is already in shift.
        if (half_done_c) begin
          state_nxt   = ST_IDLE;
          phase_nxt   = '0;
          csn_nxt     = 1'b1;
          sdo_nxt     = 1'b0;
          data_nxt    = shift[RES_MSB:RES_LSB];
          rx_done_nxt = 1'b1;
        end
      end
      ST_IDLE: begin
        if (idle_done_c) begin
          state_nxt = ST_LEAD;
          phase_nxt = '0;
          csn_nxt   = 1'b0;
          sck_nxt   = 1'b1;
          bit_nxt   = '0;
          sdo_nxt   = cmd_bit(CMD, '0);
        end
      end
      default: begin
        state_nxt = ST_STARTUP;
        phase_nxt = '0;
        csn_nxt   = 1'b1;
        sck_nxt   = 1'b1;
        sdo_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_adci_interface.sv
// tb_adci_interface: directed bench for adci_interface with a simple serial ADC model.
// Instance 1 uses defaults; instance 2 uses SCK_HALF=3, CSN_IDLE=1, CMD=16'h0800.
module tb_adci_interface;

  logic       clk = 1'b0;
  logic       en1, en2;
  logic       sdi1 = 1'b0, sdi2 = 1'b0;
  logic       sdo1, sck1, csn1, rx1;
  logic       sdo2, sck2, csn2, rx2;
  logic [7:0] data1, data2;

  logic [11:0] adc_val1, adc_val2;
  logic [15:0] adc_sr1, adc_sr2;
  logic [15:0] sdo_cap1 = 16'h0, sdo_cap2 = 16'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adci_interface u_dut1 (
    .sys_clk   (clk),
    .en        (en1),
    .SDI       (sdi1),
    .SDO       (sdo1),
    .SCK       (sck1),
    .CSN       (csn1),
    .DATA_READ (data1),
    .RX_DONE   (rx1)
  );

  adci_interface #(
    .SCK_HALF (3),
    .CSN_IDLE (1),
    .CMD      (16'h0800)
  ) u_dut2 (
    .sys_clk   (clk),
    .en        (en2),
    .SDI       (sdi2),
    .SDO       (sdo2),
    .SCK       (sck2),
    .CSN       (csn2),
    .DATA_READ (data2),
    .RX_DONE   (rx2)
  );

  // ADC model: loads {4'b0, value} when CSN falls (SCK is high then), shifts a bit out on each SCK fall.
  always @(negedge csn1 or negedge sck1) begin
    if (sck1) adc_sr1 <= {4'h0, adc_val1};
    else begin
      sdi1    <= adc_sr1[15];
      adc_sr1 <= {adc_sr1[14:0], 1'b0};
    end
  end

  always @(negedge csn2 or negedge sck2) begin
    if (sck2) adc_sr2 <= {4'h0, adc_val2};
    else begin
      sdi2    <= adc_sr2[15];
      adc_sr2 <= {adc_sr2[14:0], 1'b0};
    end
  end

  // Command bits as seen by the ADC at each SCK rise.
  always @(posedge sck1) if (!csn1) sdo_cap1 <= {sdo_cap1[14:0], sdo1};
  always @(posedge sck2) if (!csn2) sdo_cap2 <= {sdo_cap2[14:0], sdo2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for RX_DONE; reports cycles taken, SCK falls, last SCK fall spacing, DATA_READ stability.
  task automatic wait_rx(input bit sel, output int cyc, output int falls, output int gap, output bit stable);
    logic prev_sck, s, r;
    logic [7:0] d0;
    int last_fall;
    cyc = 0; falls = 0; gap = 0; stable = 1'b1; last_fall = -1;
    prev_sck = sel ? sck2 : sck1;
    d0 = sel ? data2 : data1;
    do begin
      @(negedge clk);
      cyc++;
      s = sel ? sck2 : sck1;
      r = sel ? rx2 : rx1;
      if (prev_sck && !s) begin
        falls++;
        if (last_fall >= 0) gap = cyc - last_fall;
        last_fall = cyc;
      end
      prev_sck = s;
      if (!r && ((sel ? data2 : data1) !== d0)) stable = 1'b0;
    end while (!r && cyc < 1000);
    if (!r) cyc = -1;
  endtask

  // Wait (bounded) for CSN low; flags any SCK low while CSN is high.
  task automatic wait_csn_fall(input bit sel, output int cyc, output bit sck_ok);
    cyc = 0; sck_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if ((sel ? csn2 : csn1) && !(sel ? sck2 : sck1)) sck_ok = 1'b0;
    end while ((sel ? csn2 : csn1) && cyc < 2000);
  endtask

  initial begin
    int cyc, falls, gap, nf;
    bit ok, stable, rx_seen;
    logic ps;

    en1 = 1'b0; en2 = 1'b0;
    adc_val1 = 12'hABC; adc_val2 = 12'h5A3;
    repeat (3) @(negedge clk);
    check("reset_outputs1", 32'({csn1, sck1, sdo1, rx1, data1}), 32'h0C00);
    check("reset_outputs2", 32'({csn2, sck2, sdo2, rx2, data2}), 32'h0C00);

    // Start-up delay, then first frame with 0xABC.
    en1 = 1'b1;
    wait_csn_fall(1'b0, cyc, ok);
    check("startup_cycles", 32'(cyc), 32'd256);
    check("startup_sck_idle", 32'(ok), 32'd1);
    wait_rx(1'b0, cyc, falls, gap, stable);
    check("frame1_len", 32'(cyc), 32'd68);
    check("frame1_sck_falls", 32'(falls), 32'd16);
    check("frame1_data", 32'(data1), 32'h0AB);
    check("frame1_sdo_bits", 32'(sdo_cap1), 32'h0000);
    adc_val1 = 12'hFFF;
    @(negedge clk);
    check("rx_one_cycle", 32'(rx1), 32'd0);
    check("data_hold", 32'(data1), 32'h0AB);

    // Full-scale then near-zero.
    wait_rx(1'b0, cyc, falls, gap, stable);
    adc_val1 = 12'h00F;
    check("frame2_period", 32'(cyc + 1), 32'd72);
    check("frame2_data", 32'(data1), 32'h0FF);
    check("frame2_stable", 32'(stable), 32'd1);
    @(negedge clk);
    wait_rx(1'b0, cyc, falls, gap, stable);
    adc_val1 = 12'hABC;
    check("frame3_period", 32'(cyc + 1), 32'd72);
    check("frame3_data", 32'(data1), 32'h000);
    check("frame3_sck_period", 32'(gap), 32'd4);
    check("frame3_sck_falls", 32'(falls), 32'd16);
    @(negedge clk);
    wait_rx(1'b0, cyc, falls, gap, stable);
    check("frame4_data", 32'(data1), 32'h0AB);

    // Reset in the middle of bit 7 of the next frame.
    wait_csn_fall(1'b0, cyc, ok);
    nf = 0; cyc = 0; ps = sck1;
    while (nf < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ps && !sck1) nf++;
      ps = sck1;
    end
    check("abort_reached_bit7", 32'(nf), 32'd8);
    #2 en1 = 1'b0;
    #1 check("abort_async_outputs", 32'({csn1, sck1, sdo1, rx1, data1}), 32'h0C00);
    rx_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rx1 !== 1'b0) rx_seen = 1'b1;
    end
    check("abort_no_rx", 32'(rx_seen), 32'd0);
    en1 = 1'b1;
    rx_seen = 1'b0;
    wait_csn_fall(1'b0, cyc, ok);
    check("restart_cycles", 32'(cyc), 32'd256);
    check("restart_sck_idle", 32'(ok), 32'd1);
    wait_rx(1'b0, cyc, falls, gap, stable);
    check("restart_frame_len", 32'(cyc), 32'd68);
    check("restart_data", 32'(data1), 32'h0AB);

    // Second instance: slower SCK, 1-cycle idle, channel command.
    en2 = 1'b1;
    wait_csn_fall(1'b1, cyc, ok);
    check("dut2_startup_cycles", 32'(cyc), 32'd256);
    wait_rx(1'b1, cyc, falls, gap, stable);
    adc_val2 = 12'h3C7;
    check("dut2_frame1_len", 32'(cyc), 32'd102);
    check("dut2_sck_falls", 32'(falls), 32'd16);
    check("dut2_sck_period", 32'(gap), 32'd6);
    check("dut2_data1", 32'(data2), 32'h05A);
    check("dut2_sdo_bits", 32'(sdo_cap2), 32'h0800);
    wait_rx(1'b1, cyc, falls, gap, stable);
    check("dut2_frame_period", 32'(cyc), 32'd103);
    check("dut2_data2", 32'(data2), 32'h03C);
    check("dut2_stable", 32'(stable), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
